// File: rtl/midi_msg_parser.sv
// -----------------------------------------------------------------------------
// midi_msg_parser
//
// Turns a stream of received MIDI bytes into note-on / note-off events for one
// MIDI channel and queues them in a small FIFO for the downstream voice logic.
//
// Parser: IDLE -> WAIT_D1 (status seen) -> WAIT_D2 (note seen) -> event push.
//   - 0x8n / 0x9n with n == CHANNEL starts a message.
//   - Any other status byte 0x80-0xF7 aborts the message and forgets status.
//   - Real-time bytes 0xF8-0xFF are invisible to the parser.
//   - Note-on with velocity 0 is reported as note-off; the velocity is kept.
//
// Optional feature (compile-time macro RUNNING_STATUS_EN):
//   defined   : after an event the stored status is kept and the parser waits
//               for the next note byte (MIDI running status).
//   undefined : after an event the parser returns to IDLE and forgets status;
//               data bytes arriving in IDLE are discarded.
//
// Parameters:
//   CHANNEL     MIDI channel accepted (0-15)
//   FIFO_DEPTH  event FIFO entries (power of two, 2-16)
//
// Ports:
//   clk25     in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset (release synchronised outside)
//   rx_data   in   8  received MIDI byte
//   rx_valid  in   1  strobe, rx_data valid this cycle
//   ev_valid  out  1  FIFO head holds an event
//   ev_ready  in   1  downstream accepts the head event
//   ev_on     out  1  1 = note-on, 0 = note-off
//   ev_note   out  7  note number
//   ev_vel    out  7  velocity
//   ovf       out  1  one-cycle pulse when an event is dropped (FIFO full)
// -----------------------------------------------------------------------------
module midi_msg_parser #(
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_on,
    output logic [6:0] ev_note,
    output logic [6:0] ev_vel,
    output logic       ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] CH = 4'(CHANNEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    // Parser state
    state_t      r_state;
    logic        r_stat_vld;
    logic        r_stat_on;     // 1 when stored status is 0x9n
    logic [6:0]  r_note;

    // Event FIFO: entry = {on, note[6:0], vel[6:0]}
    logic [14:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic        w_is_rt;
    logic        w_is_ours;
    logic        w_is_data;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_wr_en;
    logic [14:0] w_push_ev;
    logic [14:0] w_head;

    assign w_is_rt   = (rx_data[7:3] == 5'b11111);
    assign w_is_ours = ((rx_data[7:4] == 4'h8) || (rx_data[7:4] == 4'h9)) &&
                       (rx_data[3:0] == CH);
    assign w_is_data = rx_valid && !rx_data[7];

    // The velocity byte completes a message; the event is built straight from
    // the incoming byte so it lands in the FIFO on the sampling edge.
    assign w_push    = w_is_data && (r_state == WAIT_D2) && r_stat_vld;
    assign w_push_ev = {r_stat_on && (rx_data[6:0] != 7'd0), r_note, rx_data[6:0]};

    // ---------------------------------------------------------------------
    // Parser FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_stat_vld <= 1'b0;
            r_stat_on  <= 1'b0;
            r_note     <= 7'd0;
        end else if (rx_valid && !w_is_rt) begin
            if (rx_data[7]) begin
                if (w_is_ours) begin
                    r_stat_vld <= 1'b1;
                    r_stat_on  <= rx_data[4];
                    r_state    <= WAIT_D1;
                end else begin
                    r_stat_vld <= 1'b0;
                    r_stat_on  <= 1'b0;
                    r_state    <= IDLE;
                end
            end else begin
                case (r_state)
                    WAIT_D1: begin
                        r_note  <= rx_data[6:0];
                        r_state <= WAIT_D2;
                    end
                    WAIT_D2: begin
`ifdef RUNNING_STATUS_EN
                        r_state    <= WAIT_D1;
`else
                        r_state    <= IDLE;
                        r_stat_vld <= 1'b0;
                        r_stat_on  <= 1'b0;
`endif
                    end
                    default: begin
`ifdef RUNNING_STATUS_EN
                        // Running status: a bare data byte is the next note.
                        if (r_stat_vld) begin
                            r_note  <= rx_data[6:0];
                            r_state <= WAIT_D2;
                        end
`endif
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------------
    assign ev_valid = (r_count != '0);
    assign w_pop    = ev_valid && ev_ready;
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is accepted when the head is leaving.
    assign w_wr_en  = w_push && (!w_full || w_pop);

    always_ff @(posedge clk25) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_ev;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_ovf <= w_push && w_full && !w_pop;
        end
    end

    // Head fields are forced to zero when empty so stale or uninitialised
    // storage never reaches the outputs (including during reset).
    assign w_head  = r_mem[r_rd_ptr];
    assign ev_on   = ev_valid && w_head[14];
    assign ev_note = ev_valid ? w_head[13:7] : 7'd0;
    assign ev_vel  = ev_valid ? w_head[6:0]  : 7'd0;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_midi_msg_parser.sv
`timescale 1ns/1ps
module tb_midi_msg_parser;

    localparam int CHANNEL    = 0;
    localparam int FIFO_DEPTH = 4;

    logic       clk25    = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic       ev_on;
    logic [6:0] ev_note;
    logic [6:0] ev_vel;
    logic       ovf;

    int n_chk = 0;
    int n_err = 0;

    midi_msg_parser #(
        .CHANNEL    (CHANNEL),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk25    (clk25),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_on    (ev_on),
        .ev_note  (ev_note),
        .ev_vel   (ev_vel),
        .ovf      (ovf)
    );

    always #5 clk25 = ~clk25;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: MIDI message semantics plus a queue as the FIFO
    // ------------------------------------------------------------------
    logic [14:0] mq[$];        // expected FIFO contents {on,note,vel}
    logic [7:0]  m_data[$];    // data bytes collected for current message
    int          m_stat   = 0; // 0 none, 8 note-off status, 9 note-on status
    bit          m_active = 0; // a message is in progress
    bit          exp_ovf  = 0;

    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [14:0] e);
        ev = 0;
        e  = '0;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_data.delete();
            if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && b[3:0] == 4'(CHANNEL)) begin
                m_stat   = int'(b[7:4]);
                m_active = 1;
            end else begin
                m_stat   = 0;
                m_active = 0;
            end
            return;
        end
        if (!m_active) begin
`ifdef RUNNING_STATUS_EN
            if (m_stat != 0) begin
                m_active = 1;
                m_data.push_back(b);
            end
`endif
            return;
        end
        m_data.push_back(b);
        if (m_data.size() == 2) begin
            ev = 1;
            e  = {(m_stat == 9) && (b[6:0] != 7'd0), m_data[0][6:0], b[6:0]};
            m_data.delete();
`ifndef RUNNING_STATUS_EN
            m_stat   = 0;
            m_active = 0;
`endif
        end
    endtask

    always @(posedge clk25 or negedge rst_n) begin
        bit          full;
        bit          pop;
        bit          ev;
        logic [14:0] e;
        if (!rst_n) begin
            mq.delete();
            m_data.delete();
            m_stat   = 0;
            m_active = 0;
            exp_ovf  = 0;
        end else begin
            full = (mq.size() == FIFO_DEPTH);
            pop  = (mq.size() != 0) && ev_ready;
            ev   = 0;
            e    = '0;
            if (rx_valid) model_byte(rx_data, ev, e);
            if (pop) mq.delete(0);
            exp_ovf = 0;
            if (ev) begin
                if (full && !pop) exp_ovf = 1;
                else mq.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare on the falling edge, plus a log of consumed events
    // ------------------------------------------------------------------
    logic [14:0] dut_log[$];
    int          ovf_seen = 0;

    always @(negedge clk25) begin
        chk("ev_valid", int'(ev_valid), int'(mq.size() != 0));
        chk("ovf", int'(ovf), int'(exp_ovf));
        if (mq.size() != 0) begin
            chk("ev_on",   int'(ev_on),   int'(mq[0][14]));
            chk("ev_note", int'(ev_note), int'(mq[0][13:7]));
            chk("ev_vel",  int'(ev_vel),  int'(mq[0][6:0]));
        end
        if (ovf) ovf_seen++;
        if (rst_n && ev_valid && ev_ready) dut_log.push_back({ev_on, ev_note, ev_vel});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk25); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk25); #1;
        end
    endtask

    task automatic drain(input int n);
        ev_ready = 1'b1;
        idle(n);
        ev_ready = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [14:0] exp);
        if (idx < dut_log.size()) chk(name, int'(dut_log[idx]), int'(exp));
        else chk(name, -1, int'(exp));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ev_valid"}, int'(ev_valid), 0);
        chk({tag, " ev_on"},    int'(ev_on),    0);
        chk({tag, " ev_note"},  int'(ev_note),  0);
        chk({tag, " ev_vel"},   int'(ev_vel),   0);
        chk({tag, " ovf"},      int'(ovf),      0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        // Reset state
        @(posedge clk25); #1;
        @(posedge clk25); #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        idle(1);

        // Basic note-on, latency one cycle after the velocity strobe
        send(8'h90); send(8'h3C);
        chk("t1 valid before vel", int'(ev_valid), 0);
        send(8'h64);
        chk("t1 valid", int'(ev_valid), 1);
        chk("t1 on",    int'(ev_on),    1);
        chk("t1 note",  int'(ev_note),  'h3C);
        chk("t1 vel",   int'(ev_vel),   'h64);
        dut_log.delete();
        drain(2);
        chk("t1 drained", int'(ev_valid), 0);
        chk("t1 log size", dut_log.size(), 1);
        chk_log("t1 log0", 0, {1'b1, 7'h3C, 7'h64});

        // Velocity-0 note-on and explicit note-off
        dut_log.delete();
        send(8'h90); send(8'h40); send(8'h00);
        send(8'h80); send(8'h41); send(8'h7F);
        drain(4);
        chk("t2 log size", dut_log.size(), 2);
        chk_log("t2 log0", 0, {1'b0, 7'h40, 7'h00});
        chk_log("t2 log1", 1, {1'b0, 7'h41, 7'h7F});

        // Real-time byte inside a message is transparent
        dut_log.delete();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        drain(2);
        chk("t3 log size", dut_log.size(), 1);
        chk_log("t3 log0", 0, {1'b1, 7'h3C, 7'h64});

        // Other channel, aftertouch and system common all suppress the event
        dut_log.delete();
        send(8'h91); send(8'h3C); send(8'h64);
        chk("t3b other ch valid", int'(ev_valid), 0);
        send(8'h90); send(8'h3C); send(8'hA0); send(8'h64);
        send(8'h90); send(8'h3C); send(8'hF2); send(8'h64);
        drain(2);
        chk("t3b log size", dut_log.size(), 0);

        // Running status: second note without a status byte
        dut_log.delete();
        send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
        drain(3);
        chk_log("t4 log0", 0, {1'b1, 7'h3C, 7'h64});
`ifdef RUNNING_STATUS_EN
        chk("t4 log size", dut_log.size(), 2);
        chk_log("t4 log1", 1, {1'b1, 7'h3E, 7'h50});
`else
        chk("t4 log size", dut_log.size(), 1);
`endif

        // Overflow: five note-ons into a four-entry FIFO
        dut_log.delete();
        base = ovf_seen;
        for (int i = 0; i < 5; i++) begin
            send(8'h90); send(8'(8'h20 + i)); send(8'h40);
        end
        idle(2);
        chk("t5 ovf pulses", ovf_seen - base, 1);
        chk("t5 valid", int'(ev_valid), 1);
        chk("t5 head note", int'(ev_note), 'h20);
        drain(6);
        chk("t5 log size", dut_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_log("t5 order", i, {1'b1, 7'(7'h20 + i), 7'h40});

        // Push into a full FIFO while the head is popped: accepted, no ovf
        dut_log.delete();
        base = ovf_seen;
        for (int i = 0; i < 4; i++) begin
            send(8'h90); send(8'(8'h50 + i)); send(8'h40);
        end
        send(8'h90); send(8'h54);
        ev_ready = 1'b1;
        send(8'h40);
        ev_ready = 1'b0;
        idle(2);
        chk("t6 ovf pulses", ovf_seen - base, 0);
        drain(6);
        chk("t6 log size", dut_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk_log("t6 order", i, {1'b1, 7'(7'h50 + i), 7'h40});

        // Empty FIFO with ev_ready held high: no bypass, one cycle valid
        dut_log.delete();
        ev_ready = 1'b1;
        send(8'h90); send(8'h30);
        chk("t7 valid before", int'(ev_valid), 0);
        send(8'h31);
        chk("t7 valid", int'(ev_valid), 1);
        idle(1);
        chk("t7 valid after pop", int'(ev_valid), 0);
        ev_ready = 1'b0;
        chk("t7 log size", dut_log.size(), 1);
        chk_log("t7 log0", 0, {1'b1, 7'h30, 7'h31});

        // Reset mid-message discards the partial message
        send(8'h90);
        rst_n = 1'b0;
        idle(1);
        chk_quiet("t8 in reset");
        rst_n = 1'b1;
        idle(1);
        dut_log.delete();
        send(8'h3C); send(8'h64);
        idle(1);
        chk("t8 no event", int'(ev_valid), 0);
        drain(2);
        chk("t8 log size", dut_log.size(), 0);

        // Reset with two events queued empties the FIFO asynchronously
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3D); send(8'h65);
        chk("t9 queued valid", int'(ev_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("t9 async reset");
        idle(1);
        rst_n = 1'b1;
        idle(2);
        chk("t9 after reset valid", int'(ev_valid), 0);

        // Parser works normally after reset
        dut_log.delete();
        send(8'h90); send(8'h45); send(8'h12);
        drain(2);
        chk("t10 log size", dut_log.size(), 1);
        chk_log("t10 log0", 0, {1'b1, 7'h45, 7'h12});

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 SHALL have parameter CHANNEL, default 0, MIDI channel (0-15) accepted; all other channels ignored.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of entries in the event FIFO (power of two, 2-16).
REQ-003 SHALL have port clk25  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port rx_data  input  8  received MIDI byte from the UART byte receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port ev_valid  output  1  FIFO head holds a note event.
REQ-008 SHALL have port ev_ready  input  1  downstream voice logic accepts the head event.
REQ-009 SHALL have port ev_on  output  1  1 = note-on, 0 = note-off.
REQ-010 SHALL have port ev_note  output  7  note number.
REQ-011 SHALL have port ev_vel  output  7  velocity.
REQ-012 SHALL have port ovf  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-013 SHALL run a parser FSM with states IDLE, WAIT_D1 and WAIT_D2, and SHALL act only in cycles with rx_valid=1.
REQ-014 SHALL store status and go to WAIT_D1 on status byte 0x8n or 0x9n with n==CHANNEL.
REQ-015 SHALL clear stored status and go to IDLE on any other byte 0x80-0xF7, including other channels, 0xA0-0xEF and system common.
REQ-016 SHALL ignore real-time bytes 0xF8-0xFF, with no change to state, stored status or partial data.
REQ-017 SHALL latch data byte (bit7=0) bits[6:0] as note in WAIT_D1 and go to WAIT_D2.
REQ-018 SHALL, on a data byte in WAIT_D2, latch it as velocity and push one event {on, note, vel}.
REQ-019 SHALL set on=1 for status 0x9n with velocity>0, and on=0 for 0x8n or for 0x9n with velocity==0; ev_vel SHALL carry the received velocity unchanged.
REQ-020 SHALL leave WAIT_D2 after a push per REQ-033/REQ-034.
REQ-021 SHALL handle a data byte in IDLE per REQ-033/REQ-034.
REQ-022 SHALL write the event to the FIFO at the clock edge that samples the velocity byte; with the FIFO empty, ev_valid SHALL rise on the next cycle (latency 1).
REQ-023 SHALL drive ev_on/ev_note/ev_vel from the FIFO head, stable while ev_valid=1 and ev_ready=0.
REQ-024 SHALL pop the head on an edge where ev_valid=1 and ev_ready=1; events SHALL leave in arrival order.
REQ-025 SHALL, on a push when full with no pop in that cycle, drop the new event, keep FIFO contents and pulse ovf for exactly one cycle.
REQ-026 SHALL, on a push when full with a pop in the same cycle, accept the push and not assert ovf.
REQ-027 SHALL, on push and pop in the same cycle with the FIFO empty, hold ev_valid=0 and store the event (no bypass).
REQ-028 SHALL wrap read and write pointers modulo FIFO_DEPTH and SHALL keep an occupancy counter of width clog2(FIFO_DEPTH)+1.

Reset
REQ-029 SHALL, while rst_n=0, hold state IDLE, stored status cleared, note/velocity registers 0, and FIFO empty with pointers and count 0.
REQ-030 SHALL, while rst_n=0, drive ev_valid=0, ev_on=0, ev_note=0, ev_vel=0 and ovf=0.
REQ-031 SHALL, on reset asserted mid-message or with events queued, discard the partial message and all queued events; the first byte after release SHALL be parsed from IDLE.
REQ-032 SHALL require reset release to be synchronised to clk25 externally; the block SHALL add no release synchroniser.

Configuration
REQ-033 SHALL, when RUNNING_STATUS_EN is defined, go to WAIT_D1 after a push with stored status retained, and in IDLE with stored status valid treat a data byte as note and go to WAIT_D2.
REQ-034 SHALL, when RUNNING_STATUS_EN is undefined, go to IDLE and clear stored status after every push, and discard data bytes received in IDLE.

Verification
REQ-035 SHALL cover: CHANNEL=0, bytes 0x90,0x3C,0x64 -> one event on=1 note=0x3C vel=0x64, ev_valid high 1 cycle after the 0x64 strobe.
REQ-036 SHALL cover: 0x90,0x40,0x00 then 0x80,0x41,0x7F -> events {0,0x40,0x00} then {0,0x41,0x7F}.
REQ-037 SHALL cover: 0x90,0x3C,0xF8,0x64 -> same event as REQ-035; and 0x91,0x3C,0x64 -> no event.
REQ-038 SHALL cover: 0x90,0x3C,0x64,0x3E,0x50 -> two events with RUNNING_STATUS_EN defined, one event with it undefined.
REQ-039 SHALL cover: FIFO_DEPTH=4, ev_ready=0, 5 note-ons -> ev_valid=1, ovf pulses once on the 5th, first 4 drained in order when ev_ready=1.
REQ-040 SHALL cover: rst_n pulsed low between 0x90 and 0x3C, then 0x3C,0x64 -> no event; pulsed with 2 events queued -> ev_valid=0 after reset.
